nand_cmd_scheduler: RTL
=======================

NAND_CMD_SCHEDULER -- requirements
Module: nand_cmd_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles a target may stay busy before forced release.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, cycles after chan_done during which rb is ignored (tWB).
REQ-003 SHALL have port: clock_100  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: req0_valid / req1_valid  in  1  command pending for target 0 (ce1) / target 1 (ce2).
REQ-006 SHALL have port: req0_cmd / req1_cmd  in  8  command byte per target.
REQ-007 SHALL have port: req0_ready / req1_ready  out  1  one-cycle accept pulse; command consumed when valid & ready.
REQ-008 SHALL have port: rb1 / rb2  in  1  raw ready/busy from flash (1 = ready), asynchronous to clock_100.
REQ-009 SHALL have port: chan_cmd  out  8  command byte to channel.
REQ-010 SHALL have port: chan_ce_sel  out  1  target select (0 = ce1, 1 = ce2).
REQ-011 SHALL have port: chan_start  out  1  one-cycle pulse starting channel operation.
REQ-012 SHALL have port: chan_done  in  1  one-cycle pulse from channel at end of operation.
REQ-013 SHALL have port: tgt_busy  out  2  per-target busy flag.
REQ-014 SHALL have port: err_timeout  out  2  per-target one-cycle pulse on forced release.

Function
REQ-015 SHALL synchronize rb1/rb2 through two flops each; rb_sync visible 2 cycles after raw edge.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE: target i eligible = reqi_valid & ~tgt_busy[i] & rb_sync[i]; if any eligible, latch winner index and its cmd, go ISSUE.
REQ-018 Arbitration SHALL be round-robin: both eligible -> grant target not granted last; one eligible -> grant it.
REQ-019 ISSUE (exactly 1 cycle): chan_start=1, reqN_ready=1 for winner only, chan_ce_sel/chan_cmd = latched values; go WAIT_DONE.
REQ-020 chan_cmd and chan_ce_sel SHALL hold their values from ISSUE until the next ISSUE.
REQ-021 Latency: eligible sampled in IDLE at edge N -> chan_start high in cycle N+1.
REQ-022 WAIT_DONE: on chan_done go IDLE; set tgt_busy[winner] same edge; chan_done outside WAIT_DONE SHALL be ignored.
REQ-023 Busy target SHALL ignore rb_sync for SETTLE_CYCLES cycles after set, then clear tgt_busy when rb_sync=1.
REQ-024 Per-target timeout counter SHALL count cycles while busy; on reaching TIMEOUT_CYCLES clear tgt_busy and pulse err_timeout[i] one cycle.
REQ-025 While one target is busy the other SHALL remain schedulable (interleaving).
REQ-026 Request deasserted before ISSUE SHALL not be granted; valid dropping during ISSUE is a protocol error, behaviour unspecified.
REQ-027 Counter widths SHALL be $clog2(param+1); no wrap before terminal count.
REQ-028 rb busy->ready and timeout on same cycle: clear busy, no err_timeout pulse.

Reset
REQ-029 rst SHALL force: FSM=IDLE, chan_start=0, req*_ready=0, chan_cmd=8'h00, chan_ce_sel=0, tgt_busy=0, err_timeout=0, counters=0, sync flops=0, last-grant=1 (target 0 first).
REQ-030 rst asserted mid-operation SHALL abort immediately; no chan_start after deassertion until new eligible request seen in IDLE.

Structure
REQ-031 Package nand_sched_pkg SHALL hold FSM state enum, target index type, default TIMEOUT_CYCLES/SETTLE_CYCLES.
REQ-032 Per-target busy/settle/timeout logic plus rb synchronizer SHALL be sub-module nand_target_tracker, instantiated twice.

Verification
REQ-033 Single request: rb1=1, req0 cmd 8'h60 -> chan_start one cycle later, chan_cmd=8'h60, chan_ce_sel=0, req0_ready pulse coincident.
REQ-034 Contention: both valid (8'h60, 8'h70) each cycle -> grants alternate 0,1,0,1 after each chan_done.
REQ-035 Busy hold: after chan_done for target 0, rb1=1 constant -> tgt_busy[0] stays 1 for exactly SETTLE_CYCLES=4 cycles then clears; rb1=0 -> no grant to target 0.
REQ-036 Timeout: rb2 held 0 after target 1 op, TIMEOUT_CYCLES=16 -> err_timeout[1] pulse at cycle 16, tgt_busy[1]=0.
REQ-037 Reset in WAIT_DONE -> all outputs at reset values, later chan_done ignored, next request issues normally.
REQ-038 Interleave: target 0 busy, req1 valid with rb2=1 -> target 1 issued while tgt_busy[0]=1.

Source files
------------

// File: rtl/nand_sched_pkg.sv
// Shared types and defaults for the two-target NAND command scheduler.
// Holds the FSM encoding, the target index type and the round-robin pick helper.
package nand_sched_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_SETTLE_CYCLES  = 4;

    typedef logic tgt_idx_t;

    localparam tgt_idx_t TGT_0 = 1'b0;
    localparam tgt_idx_t TGT_1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } sched_state_t;

    // With both targets eligible the one not served last wins.
    function automatic tgt_idx_t rr_winner(input logic [1:0] elig, input tgt_idx_t last_grant);
        tgt_idx_t win;
        if (elig == 2'b11) begin
            win = ~last_grant;
        end else if (elig[0]) begin
            win = TGT_0;
        end else begin
            win = TGT_1;
        end
        return win;
    endfunction

endpackage

// File: rtl/nand_target_tracker.sv
// Per-target ready/busy tracking: rb synchronizer, post-operation settle window
// and busy timeout with a one-cycle error pulse on forced release.
module nand_target_tracker
    import nand_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic clock_100,
    input  logic rst,
    input  logic rb_raw,
    input  logic set_busy,
    output logic rb_sync,
    output logic busy,
    output logic err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_ZERO = TW'(0);
    localparam logic [SW-1:0] ST_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] ST_ONE  = SW'(1);
    localparam logic [SW-1:0] ST_ZERO = SW'(0);

    logic          rb_meta_r;
    logic          rb_sync_r;
    logic          busy_r;
    logic          err_r;
    logic [SW-1:0] settle_cnt_r;
    logic [TW-1:0] timeout_cnt_r;

    logic          busy_n_s;
    logic          err_n_s;
    logic [SW-1:0] settle_n_s;
    logic [TW-1:0] timeout_n_s;

    // Two-flop synchronizer for the asynchronous ready/busy line.
    always_ff @(posedge clock_100 or posedge rst) begin
        if (rst) begin
            rb_meta_r <= 1'b0;
            rb_sync_r <= 1'b0;
        end else begin
            rb_meta_r <= rb_raw;
            rb_sync_r <= rb_meta_r;
        end
    end

    // Busy, settle and timeout next-state; settle counts down and rb is honoured once it reaches one.
    always_comb begin
        busy_n_s    = busy_r;
        err_n_s     = 1'b0;
        settle_n_s  = settle_cnt_r;
        timeout_n_s = timeout_cnt_r;
        if (set_busy) begin
            busy_n_s    = 1'b1;
            settle_n_s  = ST_LOAD;
            timeout_n_s = TO_ZERO;
        end else if (busy_r) begin
            if (settle_cnt_r > ST_ONE) begin
                settle_n_s = settle_cnt_r - ST_ONE;
            end else begin
                settle_n_s = settle_cnt_r;
            end
            // A ready release on the terminal cycle wins over the timeout.
            if ((settle_cnt_r <= ST_ONE) && rb_sync_r) begin
                busy_n_s    = 1'b0;
                settle_n_s  = ST_ZERO;
                timeout_n_s = TO_ZERO;
            end else if (timeout_cnt_r == TO_LAST) begin
                busy_n_s    = 1'b0;
                err_n_s     = 1'b1;
                settle_n_s  = ST_ZERO;
                timeout_n_s = TO_ZERO;
            end else begin
                timeout_n_s = timeout_cnt_r + TO_ONE;
            end
        end else begin
            settle_n_s  = ST_ZERO;
            timeout_n_s = TO_ZERO;
        end
    end

    // Busy tracking state registers.
    always_ff @(posedge clock_100 or posedge rst) begin
        if (rst) begin
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
            settle_cnt_r  <= ST_ZERO;
            timeout_cnt_r <= TO_ZERO;
        end else begin
            busy_r        <= busy_n_s;
            err_r         <= err_n_s;
            settle_cnt_r  <= settle_n_s;
            timeout_cnt_r <= timeout_n_s;
        end
    end

    assign rb_sync     = rb_sync_r;
    assign busy        = busy_r;
    assign err_timeout = err_r;

endmodule

// File: rtl/nand_cmd_scheduler.sv
// Two-target NAND command scheduler: round-robin grant of pending commands to a
// shared channel, skipping targets that are still busy after their last operation.
module nand_cmd_scheduler
    import nand_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic       clock_100,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_cmd,
    input  logic [7:0] req1_cmd,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic       rb1,
    input  logic       rb2,
    output logic [7:0] chan_cmd,
    output logic       chan_ce_sel,
    output logic       chan_start,
    input  logic       chan_done,
    output logic [1:0] tgt_busy,
    output logic [1:0] err_timeout
);

    sched_state_t state_r;
    sched_state_t state_n_s;
    logic         chan_start_r;
    logic         chan_start_n_s;
    logic [1:0]   ready_r;
    logic [1:0]   ready_n_s;
    logic [7:0]   chan_cmd_r;
    logic [7:0]   chan_cmd_n_s;
    tgt_idx_t     chan_ce_sel_r;
    tgt_idx_t     chan_ce_sel_n_s;
    tgt_idx_t     last_grant_r;
    tgt_idx_t     last_grant_n_s;
    tgt_idx_t     win_s;
    logic [1:0]   elig_s;
    logic [1:0]   set_busy_s;
    logic [1:0]   rb_sync_s;
    logic [1:0]   busy_s;
    logic [1:0]   err_s;

    nand_target_tracker #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) u_tgt0 (
        .clock_100   (clock_100),
        .rst         (rst),
        .rb_raw      (rb1),
        .set_busy    (set_busy_s[0]),
        .rb_sync     (rb_sync_s[0]),
        .busy        (busy_s[0]),
        .err_timeout (err_s[0])
    );

    nand_target_tracker #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) u_tgt1 (
        .clock_100   (clock_100),
        .rst         (rst),
        .rb_raw      (rb2),
        .set_busy    (set_busy_s[1]),
        .rb_sync     (rb_sync_s[1]),
        .busy        (busy_s[1]),
        .err_timeout (err_s[1])
    );

    // Next-state and next-output logic for the issue sequencer.
    always_comb begin
        elig_s[0]       = req0_valid & ~busy_s[0] & rb_sync_s[0];
        elig_s[1]       = req1_valid & ~busy_s[1] & rb_sync_s[1];
        state_n_s       = state_r;
        chan_start_n_s  = 1'b0;
        ready_n_s       = 2'b00;
        chan_cmd_n_s    = chan_cmd_r;
        chan_ce_sel_n_s = chan_ce_sel_r;
        last_grant_n_s  = last_grant_r;
        set_busy_s      = 2'b00;
        win_s           = rr_winner(elig_s, last_grant_r);
        case (state_r)
            ST_IDLE: begin
                if (elig_s != 2'b00) begin
                    state_n_s         = ST_ISSUE;
                    chan_start_n_s    = 1'b1;
                    ready_n_s[win_s]  = 1'b1;
                    chan_ce_sel_n_s   = win_s;
                    last_grant_n_s    = win_s;
                    if (win_s == TGT_1) begin
                        chan_cmd_n_s = req1_cmd;
                    end else begin
                        chan_cmd_n_s = req0_cmd;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_n_s = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (chan_done) begin
                    state_n_s                 = ST_IDLE;
                    set_busy_s[chan_ce_sel_r] = 1'b1;
                end else begin
                    state_n_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered channel/handshake outputs.
    always_ff @(posedge clock_100 or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            chan_start_r  <= 1'b0;
            ready_r       <= 2'b00;
            chan_cmd_r    <= 8'h00;
            chan_ce_sel_r <= TGT_0;
            last_grant_r  <= TGT_1;
        end else begin
            state_r       <= state_n_s;
            chan_start_r  <= chan_start_n_s;
            ready_r       <= ready_n_s;
            chan_cmd_r    <= chan_cmd_n_s;
            chan_ce_sel_r <= chan_ce_sel_n_s;
            last_grant_r  <= last_grant_n_s;
        end
    end

    assign chan_start  = chan_start_r;
    assign req0_ready  = ready_r[0];
    assign req1_ready  = ready_r[1];
    assign chan_cmd    = chan_cmd_r;
    assign chan_ce_sel = chan_ce_sel_r;
    assign tgt_busy    = busy_s;
    assign err_timeout = err_s;

endmodule
